// File: rtl/score_collector.sv
// Collects ten class scores per frame, launches the argmax stage and latches its result.
// Optional SCORE_LAST_CHECK_EN: validate score_last framing and flag malformed frames.
module score_collector #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                score_valid,
    input  logic [WIDTH-1:0]    score_data,
    input  logic                score_last,
    output logic                score_ready,
    output logic [10*WIDTH-1:0] scores,
    output logic                start,
    input  logic                done,
    input  logic [3:0]          digit_in,
    output logic [3:0]          digit_out,
    output logic                digit_valid,
    output logic                frame_err
);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [10*WIDTH-1:0] scores_q, scores_d;
    logic [3:0]          digit_q, digit_d;
    logic                digit_valid_q, digit_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                last_beat;
    logic                bad_frame;

    assign last_beat = (cnt_q == 4'd9);

`ifdef SCORE_LAST_CHECK_EN
    assign bad_frame = (score_last != last_beat);
`else
    logic unused_score_last;
    assign unused_score_last = score_last;
    assign bad_frame         = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        scores_d      = scores_q;
        digit_d       = digit_q;
        digit_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (score_valid) begin
                    for (int k = 0; k < 10; k++) begin
                        if (cnt_q == 4'(k)) scores_d[k*WIDTH +: WIDTH] = score_data;
                    end
                    // A malformed frame is dropped; lanes already written stay as they are.
                    if (bad_frame) begin
                        cnt_d       = 4'd0;
                        frame_err_d = 1'b1;
                    end else if (last_beat) begin
                        cnt_d   = 4'd0;
                        state_d = ISSUE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (done) begin
                    digit_d       = digit_in;
                    digit_valid_d = 1'b1;
                    state_d       = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= COLLECT;
            cnt_q         <= 4'd0;
            scores_q      <= '0;
            digit_q       <= 4'd0;
            digit_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            scores_q      <= scores_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign score_ready = (state_q == COLLECT);
    assign start       = (state_q == ISSUE);
    assign scores      = scores_q;
    assign digit_out   = digit_q;
    assign digit_valid = digit_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_score_collector.sv
// Randomized self-checking bench for score_collector; expected lanes come from the
// beat list of each frame and expected digits from the done stimulus.
module tb_score_collector;

    localparam int WIDTH = 32;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                score_valid = 1'b0;
    logic [WIDTH-1:0]    score_data = '0;
    logic                score_last = 1'b0;
    logic                score_ready;
    logic [10*WIDTH-1:0] scores;
    logic                start;
    logic                done = 1'b0;
    logic [3:0]          digit_in = 4'd0;
    logic [3:0]          digit_out;
    logic                digit_valid;
    logic                frame_err;

    score_collector #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .score_valid (score_valid),
        .score_data  (score_data),
        .score_last  (score_last),
        .score_ready (score_ready),
        .scores      (scores),
        .start       (start),
        .done        (done),
        .digit_in    (digit_in),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;
    int dv_cnt    = 0;
    int err_cnt   = 0;
    logic [WIDTH-1:0] beat_vals [10];
    logic [3:0]       exp_digit = 4'd0;

    // Pulse counters, sampled at the edge that closes each cycle.
    always @(posedge clk) begin
        if (start)       start_cnt <= start_cnt + 1;
        if (digit_valid) dv_cnt    <= dv_cnt + 1;
        if (frame_err)   err_cnt   <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_lanes(input string tag);
        for (int k = 0; k < 10; k++)
            check($sformatf("%s_lane%0d", tag, k), 64'(scores[k*WIDTH +: WIDTH]),
                  64'(beat_vals[k]));
    endtask

    task automatic randomize_vals();
        for (int k = 0; k < 10; k++) beat_vals[k] = $urandom;
    endtask

    // Drive beats first..last-1; gap_mode 0 none, 1 one idle cycle, 2 random 0..2.
    task automatic send_beats(input int first, input int last, input int last_idx,
                              input int gap_mode, input int done_idx);
        for (int k = first; k < last; k++) begin
            int gaps;
            int guard;
            gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            score_valid = 1'b0;
            repeat (gaps) @(negedge clk);
            score_valid = 1'b1;
            score_data  = beat_vals[k];
            score_last  = (k == last_idx);
            if (k == done_idx) begin
                done     = 1'b1;
                digit_in = ~exp_digit;
            end
            guard = 0;
            while (!score_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (guard == 20) check("ready_timeout", 64'(score_ready), 64'd1);
            @(negedge clk);
            done = 1'b0;
        end
        score_valid = 1'b0;
        score_last  = 1'b0;
    endtask

    // Entered in the cycle after the 10th beat was accepted.
    task automatic issue_and_done(input int delay, input logic [3:0] dig);
        check("start_pulse", 64'(start), 64'd1);
        check("ready_issue", 64'(score_ready), 64'd0);
        @(negedge clk);
        check("start_once", 64'(start), 64'd0);
        check("ready_wait", 64'(score_ready), 64'd0);
        repeat (delay - 1) @(negedge clk);
        check("digit_hold", 64'(digit_out), 64'(exp_digit));
        check("ready_wait_late", 64'(score_ready), 64'd0);
        done     = 1'b1;
        digit_in = dig;
        @(negedge clk);
        done      = 1'b0;
        exp_digit = dig;
        check("digit_valid", 64'(digit_valid), 64'd1);
        check("digit_out", 64'(digit_out), 64'(exp_digit));
        check("ready_back", 64'(score_ready), 64'd1);
        @(negedge clk);
        check("digit_valid_once", 64'(digit_valid), 64'd0);
        check("digit_keep", 64'(digit_out), 64'(exp_digit));
    endtask

    initial begin
        int s0, d0, e0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_ready", 64'(score_ready), 64'd1);
        check("rst_scores", 64'(|scores), 64'd0);
        check("rst_start", 64'(start), 64'd0);
        check("rst_digit", 64'(digit_out), 64'd0);
        check("rst_dv", 64'(digit_valid), 64'd0);
        check("rst_err", 64'(frame_err), 64'd0);

        // Back-to-back frame 0x10..0x19, done three cycles after start.
        for (int k = 0; k < 10; k++) beat_vals[k] = WIDTH'(32'h10 + k);
        s0 = start_cnt;
        send_beats(0, 10, 9, 0, -1);
        check_lanes("b2b");
        issue_and_done(3, 4'd7);
        check_lanes("b2b_held");

        // Same frame with an idle cycle before every beat.
        send_beats(0, 10, 9, 1, -1);
        check_lanes("gappy");
        issue_and_done(2, 4'(exp_digit + 4'd3));
        repeat (2) @(negedge clk);
        check("start_count_dir", 64'(start_cnt - s0), 64'd2);

        // Random frames; the first also carries a stray done at beat 4.
        for (int it = 0; it < 4; it++) begin
            s0 = start_cnt;
            d0 = dv_cnt;
            randomize_vals();
            send_beats(0, 10, 9, 2, (it == 0) ? 4 : -1);
            check_lanes($sformatf("rnd%0d", it));
            check("rnd_digit_kept", 64'(digit_out), 64'(exp_digit));
            issue_and_done(int'($urandom_range(1, 5)), 4'($urandom_range(0, 9)));
            repeat (2) @(negedge clk);
            check("rnd_start_count", 64'(start_cnt - s0), 64'd1);
            check("rnd_dv_count", 64'(dv_cnt - d0), 64'd1);
        end

        // Reset after beat 5 discards the partial frame.
        randomize_vals();
        send_beats(0, 6, -1, 0, -1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_digit = 4'd0;
        check("midrst_scores", 64'(|scores), 64'd0);
        check("midrst_digit", 64'(digit_out), 64'd0);
        s0 = start_cnt;
        randomize_vals();
        send_beats(0, 10, 9, 2, -1);
        check_lanes("after_rst");
        issue_and_done(3, 4'd5);
        repeat (2) @(negedge clk);
        check("rst_start_count", 64'(start_cnt - s0), 64'd1);

        // score_last raised early on beat 3.
        s0 = start_cnt;
        e0 = err_cnt;
        randomize_vals();
        send_beats(0, 4, 3, 0, -1);
`ifdef SCORE_LAST_CHECK_EN
        check("early_last_err", 64'(frame_err), 64'd1);
        check("early_last_ready", 64'(score_ready), 64'd1);
        @(negedge clk);
        check("early_last_err_once", 64'(frame_err), 64'd0);
        check("early_last_no_start", 64'(start), 64'd0);
        randomize_vals();
        send_beats(0, 10, 9, 0, -1);
        check_lanes("post_err");
        issue_and_done(2, 4'd9);
        repeat (2) @(negedge clk);
        check("err_count", 64'(err_cnt - e0), 64'd1);
`else
        check("early_last_no_err", 64'(frame_err), 64'd0);
        check("early_last_no_start", 64'(start), 64'd0);
        send_beats(4, 10, -1, 0, -1);
        check_lanes("count_only");
        issue_and_done(2, 4'd9);
        repeat (2) @(negedge clk);
        check("err_count", 64'(err_cnt - e0), 64'd0);
`endif
        check("last_start_count", 64'(start_cnt - s0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/score_collector.md
SCORE_COLLECTOR -- requirements
Module: score_collector

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 32, the bit width of one class score.
REQ-002 The block SHALL have input clk, 1 bit, the rising-edge clock.
REQ-003 The block SHALL have input reset, 1 bit, a synchronous, active-high reset.
REQ-004 The block SHALL have input score_valid, 1 bit, meaning the upstream beat on score_data is valid.
REQ-005 The block SHALL have input score_data, WIDTH bits, carrying one class score per beat.
REQ-006 The block SHALL have input score_last, 1 bit, which upstream raises on the final beat of a frame.
REQ-007 The block SHALL have output score_ready, 1 bit, meaning the block accepts a beat this cycle.
REQ-008 The block SHALL have output scores, 10*WIDTH bits, the packed score vector sent to the argmax stage.
REQ-009 The block SHALL have output start, 1 bit, a one-cycle pulse that launches the argmax stage.
REQ-010 The block SHALL have input done, 1 bit, the argmax-stage completion pulse.
REQ-011 The block SHALL have input digit_in, 4 bits, the argmax result, valid when done is high.
REQ-012 The block SHALL have output digit_out, 4 bits, the last latched predicted digit.
REQ-013 The block SHALL have output digit_valid, 1 bit, a one-cycle pulse raised when digit_out updates.
REQ-014 The block SHALL have output frame_err, 1 bit, a one-cycle pulse that flags a malformed frame.

Function
REQ-015 FSM states SHALL be COLLECT, ISSUE and WAIT.
REQ-016 In COLLECT: score_ready=1 — a beat is accepted when score_valid && score_ready; beat k of the frame (k = 0..9) SHALL be written to scores[k*WIDTH +: WIDTH]; lane counter cnt increments per accepted beat.
REQ-017 Acceptance of beat 9 (the 10th beat) SHALL clear cnt to 0 and move COLLECT->ISSUE on the next edge — no gap cycles required between beats; score_valid low stalls without loss.
REQ-018 In ISSUE: start=1 for exactly one cycle, score_ready=0; then ISSUE->WAIT unconditionally.
REQ-019 In WAIT: score_ready=0; on done=1 SHALL latch digit_in into digit_out, pulse digit_valid the following cycle, and return WAIT->COLLECT.
REQ-020 Latency: last beat accepted at edge N -> start high in cycle N+1; done at edge D -> digit_valid high in cycle D+1.
REQ-021 scores SHALL be held constant from the edge entering ISSUE until the first beat of the next frame is accepted.
REQ-022 done received in COLLECT or ISSUE SHALL be ignored (no latch, no digit_valid).
REQ-023 digit_out SHALL hold its value between updates; score_data has no arithmetic or sign interpretation — it is passed bit-exact.
REQ-024 WAIT has no timeout — the block SHALL remain in WAIT until done.

Reset
REQ-025 On reset=1 at an edge, the block SHALL enter COLLECT with cnt=0, scores=0, start=0, digit_out=0, digit_valid=0, frame_err=0; score_ready=1 in the first cycle after reset.
REQ-026 Reset mid-frame or in WAIT SHALL discard partial data and any pending result; a done arriving after reset SHALL be ignored per REQ-022.

Configuration
REQ-027 Macro SCORE_LAST_CHECK_EN: when defined, the block SHALL check score_last on every accepted beat as follows:
 - score_last=1 on beat k<9, or score_last=0 on beat 9 -> frame_err pulses in the next cycle.
 - On that error, cnt returns to 0, the frame is dropped (no ISSUE) and the FSM stays in COLLECT.
 - scores lanes already written are not cleared.
REQ-028 When SCORE_LAST_CHECK_EN is undefined, score_last SHALL be ignored, frame_err tied 0, and frames are delimited by count alone.

Verification
REQ-029 Stream 10 back-to-back beats 0x10..0x19 (score_last on the 10th) -> start pulse in the cycle after the 10th beat; scores lane k = 0x10+k; score_ready=0 in ISSUE and WAIT.
REQ-030 Same frame with score_valid low every other cycle -> identical scores and a single start pulse.
REQ-031 In WAIT, drive done=1 with digit_in=7 three cycles after start -> digit_out=7, digit_valid high for exactly 1 cycle in the next cycle, score_ready=1 again.
REQ-032 Pulse done while in COLLECT at beat 4 -> digit_out unchanged, no digit_valid, frame continues to completion.
REQ-033 Assert reset after beat 5, then send a full frame -> exactly one start; lanes 0..9 hold only the new frame's data.
REQ-034 With SCORE_LAST_CHECK_EN defined, set score_last on beat 3 -> frame_err pulses once, no start; the next well-formed frame issues normally. Undefined: same stimulus -> no frame_err; start after 10 beats.
